// File: rtl/uart_tx_ctrl.sv
// UART Tx framer: start, DATA_WIDTH data bits LSB first, optional parity, stop; first line bit one cycle after the load edge.
// No backpressure: Data_Valid is dropped while Busy, except during STOP when UART_TX_BACK2BACK_EN is defined.
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  par_bit,
    output logic                  TX_OUT,
    output logic                  Busy
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

`ifdef UART_TX_BACK2BACK_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state_q;
    logic [DATA_WIDTH-1:0] shreg_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  par_q;
    logic                  par_en_q;
    logic                  tx_q;
    logic                  busy_q;
    logic                  load_d;

    always_comb begin
        load_d = Data_Valid && ((state_q == IDLE) || (B2B && (state_q == STOP)));
    end

    // State names what is on the line now; outputs are computed one state ahead.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            cnt_q    <= '0;
            par_q    <= 1'b0;
            par_en_q <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else if (load_d) begin
            state_q  <= START;
            shreg_q  <= P_DATA;
            par_en_q <= PAR_EN;
            tx_q     <= 1'b0;
            busy_q   <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                end
                START: begin
                    par_q   <= par_bit;
                    cnt_q   <= '0;
                    tx_q    <= shreg_q[0];
                    shreg_q <= shreg_q >> 1;
                    state_q <= DATA;
                end
                DATA: begin
                    if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                        if (par_en_q) begin
                            tx_q    <= par_q;
                            state_q <= PARITY;
                        end else begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end
                    end else begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                        tx_q    <= shreg_q[0];
                        shreg_q <= shreg_q >> 1;
                    end
                end
                PARITY: begin
                    tx_q    <= 1'b1;
                    state_q <= STOP;
                end
                STOP: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign TX_OUT = tx_q;
    assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl; inputs driven and outputs sampled on the falling edge.
module tb_uart_tx_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] P_DATA = 8'h00;
    logic       Data_Valid = 1'b0;
    logic       PAR_EN = 1'b0;
    logic       par_bit = 1'b0;
    logic       TX_OUT;
    logic       Busy;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .par_bit    (par_bit),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    initial forever #5 CLK = ~CLK;

    // Stimulus only: one-cycle strobe; returns at the falling edge of the start-bit cycle.
    task automatic strobe(input logic [7:0] d, input logic pen);
        @(negedge CLK);
        Data_Valid = 1'b1;
        P_DATA     = d;
        PAR_EN     = pen;
        @(negedge CLK);
        Data_Valid = 1'b0;
    endtask

    task automatic test_reset;
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        n_checks++;
        if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: tx=%b busy=%b, want tx=1 busy=0", TX_OUT, Busy);
        end
        RST = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            n_checks++;
            if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_idle[%0d]: tx=%b busy=%b, want tx=1 busy=0", i, TX_OUT, Busy);
            end
        end
    endtask

    task automatic test_parity_frame;
        bit exp [0:10];
        exp = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
        par_bit = 1'b0;
        strobe(8'hA5, 1'b1);
        for (int i = 0; i < 11; i++) begin
            if (i > 0) @(negedge CLK);
            n_checks++;
            if (TX_OUT !== exp[i] || Busy !== 1'b1) begin
                n_fail++;
                $display("FAIL a5_par bit%0d: tx=%b busy=%b, want tx=%b busy=1", i, TX_OUT, Busy, exp[i]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            n_checks++;
            if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
                n_fail++;
                $display("FAIL a5_par idle%0d: tx=%b busy=%b, want tx=1 busy=0", i, TX_OUT, Busy);
            end
        end
    endtask

    task automatic test_no_parity_frame;
        bit exp [0:9];
        exp = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 1};
        par_bit = 1'b1;
        strobe(8'h3C, 1'b0);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge CLK);
            n_checks++;
            if (TX_OUT !== exp[i] || Busy !== 1'b1) begin
                n_fail++;
                $display("FAIL 3c_nopar bit%0d: tx=%b busy=%b, want tx=%b busy=1", i, TX_OUT, Busy, exp[i]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            n_checks++;
            if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
                n_fail++;
                $display("FAIL 3c_nopar idle%0d: tx=%b busy=%b, want tx=1 busy=0", i, TX_OUT, Busy);
            end
        end
    endtask

    task automatic test_midframe_ignore;
        bit exp [0:10];
        exp = '{0, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1};
        par_bit = 1'b1;
        strobe(8'h0F, 1'b1);
        for (int i = 0; i < 11; i++) begin
            if (i > 0) @(negedge CLK);
            n_checks++;
            if (TX_OUT !== exp[i] || Busy !== 1'b1) begin
                n_fail++;
                $display("FAIL midframe bit%0d: tx=%b busy=%b, want tx=%b busy=1", i, TX_OUT, Busy, exp[i]);
            end
            if (i == 3) begin
                Data_Valid = 1'b1;
                P_DATA     = 8'hFF;
                PAR_EN     = 1'b0;
                par_bit    = 1'b0;
            end
            if (i == 4) Data_Valid = 1'b0;
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            n_checks++;
            if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
                n_fail++;
                $display("FAIL midframe idle%0d: tx=%b busy=%b, want tx=1 busy=0", i, TX_OUT, Busy);
            end
        end
    endtask

    task automatic test_reset_midframe;
        bit exp_a [0:4];
        bit exp_b [0:9];
        exp_a = '{0, 1, 0, 1, 0};
        exp_b = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 1};
        par_bit = 1'b0;
        strobe(8'hA5, 1'b1);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge CLK);
            n_checks++;
            if (TX_OUT !== exp_a[i] || Busy !== 1'b1) begin
                n_fail++;
                $display("FAIL rstmid pre bit%0d: tx=%b busy=%b, want tx=%b busy=1", i, TX_OUT, Busy, exp_a[i]);
            end
        end
        RST = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid truncate: tx=%b busy=%b, want tx=1 busy=0", TX_OUT, Busy);
        end
        RST = 1'b1;
        strobe(8'h3C, 1'b0);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge CLK);
            n_checks++;
            if (TX_OUT !== exp_b[i] || Busy !== 1'b1) begin
                n_fail++;
                $display("FAIL rstmid post bit%0d: tx=%b busy=%b, want tx=%b busy=1", i, TX_OUT, Busy, exp_b[i]);
            end
        end
        @(negedge CLK);
        n_checks++;
        if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid post idle: tx=%b busy=%b, want tx=1 busy=0", TX_OUT, Busy);
        end
    endtask

    task automatic test_back_to_back;
        bit exp [0:21];
        exp = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1,
                0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
        par_bit = 1'b1;
        strobe(8'h01, 1'b1);
        for (int i = 0; i < 11; i++) begin
            if (i > 0) @(negedge CLK);
            n_checks++;
            if (TX_OUT !== exp[i] || Busy !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b f1 bit%0d: tx=%b busy=%b, want tx=%b busy=1", i, TX_OUT, Busy, exp[i]);
            end
            if (i == 10) begin
                Data_Valid = 1'b1;
                P_DATA     = 8'h80;
            end
        end
`ifdef UART_TX_BACK2BACK_EN
        for (int i = 11; i < 22; i++) begin
            @(negedge CLK);
            if (i == 11) Data_Valid = 1'b0;
            n_checks++;
            if (TX_OUT !== exp[i] || Busy !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b f2 bit%0d: tx=%b busy=%b, want tx=%b busy=1", i, TX_OUT, Busy, exp[i]);
            end
        end
        @(negedge CLK);
        n_checks++;
        if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b end idle: tx=%b busy=%b, want tx=1 busy=0", TX_OUT, Busy);
        end
`else
        for (int i = 0; i < 11; i++) begin
            @(negedge CLK);
            if (i == 0) Data_Valid = 1'b0;
            n_checks++;
            if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b ignored idle%0d: tx=%b busy=%b, want tx=1 busy=0", i, TX_OUT, Busy);
            end
        end
`endif
    endtask

    initial begin
        test_reset();
        test_parity_frame();
        test_no_parity_frame();
        test_midframe_ignore();
        test_reset_midframe();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
